// File: rtl/time_adjust_ctrl_pkg.sv
// Shared types and constants for the time-adjust key front-end.
package time_adjust_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_e;

  localparam logic [3:0] SEL_MS_L  = 4'd0;
  localparam logic [3:0] SEL_MS_H  = 4'd1;
  localparam logic [3:0] SEL_SEC_L = 4'd2;
  localparam logic [3:0] SEL_SEC_H = 4'd3;
  localparam logic [3:0] SEL_MIN_L = 4'd4;
  localparam logic [3:0] SEL_MIN_H = 4'd5;
  localparam logic [3:0] SEL_HR_L  = 4'd6;
  localparam logic [3:0] SEL_HR_H  = 4'd7;
  localparam logic [3:0] SEL_DAY_L = 4'd8;
  localparam logic [3:0] SEL_DAY_H = 4'd9;
  localparam logic [3:0] SEL_MON_L = 4'd10;
  localparam logic [3:0] SEL_MON_H = 4'd11;
  localparam logic [3:0] SEL_YR_1  = 4'd12;
  localparam logic [3:0] SEL_YR_2  = 4'd13;
  localparam logic [3:0] SEL_YR_3  = 4'd14;
  localparam logic [3:0] SEL_YR_4  = 4'd15;

  localparam int unsigned DEF_DB_CYCLES  = 1_000_000;
  localparam int unsigned DEF_REP_DELAY  = 25_000_000;
  localparam int unsigned DEF_REP_PERIOD = 5_000_000;
  localparam int unsigned DEF_PULSE_W    = 2;
  localparam int unsigned DEF_BLINK_HALF = 12_500_000;

  // Bits needed to hold values 0..max_val (at least one).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/time_adjust_ctrl_key_debounce.sv
// One raw active-low key: 2-FF synchroniser, debounce counter, press strobe.
module key_debounce
  import time_adjust_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = cnt_w(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Level flips after DB_CYCLES consecutive samples disagreeing with it.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if ((~sync2_q) != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_adjust_ctrl.sv
// Key front-end for the time counter chain: RUN/EDIT mode machine, add/clr
// pulse generator with auto-repeat, digit select and edit blink strobe.
module time_adjust_ctrl
  import time_adjust_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
  parameter int unsigned REP_PERIOD = DEF_REP_PERIOD,
  parameter int unsigned PULSE_W    = DEF_PULSE_W,
  parameter int unsigned BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_next_n,
  input  logic       key_add_n,
  input  logic       key_clr_n,
  output logic       adjust,
  output logic [3:0] select,
  output logic       add,
  output logic       clr,
  output logic       blink
);

  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned REP_W   = cnt_w(REP_MAX - 1);
  localparam int unsigned BUSY_W  = cnt_w(2 * PULSE_W - 1);
  localparam int unsigned BLINK_W = cnt_w(BLINK_HALF - 1);

  logic press_mode, press_next, press_add, press_clr;
  logic lvl_mode, lvl_next, lvl_add, lvl_clr;
  logic unused_lvls;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .CLOCK_50(CLOCK_50), .rst(rst), .key_n(key_mode_n), .level(lvl_mode), .press(press_mode)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .CLOCK_50(CLOCK_50), .rst(rst), .key_n(key_next_n), .level(lvl_next), .press(press_next)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_add (
    .CLOCK_50(CLOCK_50), .rst(rst), .key_n(key_add_n), .level(lvl_add), .press(press_add)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .CLOCK_50(CLOCK_50), .rst(rst), .key_n(key_clr_n), .level(lvl_clr), .press(press_clr)
  );

  assign unused_lvls = lvl_mode ^ lvl_next ^ lvl_clr;

  state_e               state_q,     state_d;
  logic                 adjust_q,    adjust_d;
  logic [3:0]           select_q,    select_d;
  logic                 add_q,       add_d;
  logic                 clr_q,       clr_d;
  logic                 clr_kind_q,  clr_kind_d;
  logic [BUSY_W-1:0]    busy_q,      busy_d;
  logic                 mode_pend_q, mode_pend_d;
  logic                 rep_on_q,    rep_on_d;
  logic [REP_W-1:0]     rep_cnt_q,   rep_cnt_d;
  logic                 blink_q,     blink_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;

  logic busy, pulse_on, fire_add, fire_clr, sel_chg, enter_edit;

  assign busy     = (busy_q != '0);
  assign pulse_on = add_q | clr_q;

  // busy_q spans the pulse plus its trailing gap; events are only taken when idle.
  always_comb begin
    state_d     = state_q;
    adjust_d    = adjust_q;
    select_d    = select_q;
    busy_d      = busy ? (busy_q - BUSY_W'(1)) : '0;
    clr_kind_d  = clr_kind_q;
    mode_pend_d = mode_pend_q;
    rep_on_d    = rep_on_q;
    rep_cnt_d   = rep_cnt_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    fire_add    = 1'b0;
    fire_clr    = 1'b0;
    sel_chg     = 1'b0;
    enter_edit  = 1'b0;

    if (press_mode || press_next || press_clr) rep_on_d = 1'b0;

    if (press_mode || mode_pend_q) begin
      // Mode toggles wait until add/clr are low so adjust never moves mid-pulse.
      if (pulse_on) begin
        mode_pend_d = 1'b1;
      end else begin
        mode_pend_d = 1'b0;
        if (state_q == ST_RUN) begin
          state_d    = ST_EDIT;
          adjust_d   = 1'b0;
          enter_edit = 1'b1;
        end else begin
          state_d  = ST_RUN;
          adjust_d = 1'b1;
          rep_on_d = 1'b0;
        end
      end
    end else if (state_q == ST_EDIT) begin
      if (press_clr) begin
        fire_clr = !busy;
      end else if (press_add) begin
        if (!busy) begin
          fire_add  = 1'b1;
          rep_on_d  = 1'b1;
          rep_cnt_d = REP_W'(REP_DELAY - 1);
        end
      end else if (press_next) begin
        if (!pulse_on) begin
          select_d = select_q + 4'd1;
          sel_chg  = 1'b1;
        end
      end else if (rep_on_q) begin
        if (!lvl_add) begin
          rep_on_d = 1'b0;
        end else if (rep_cnt_q == '0) begin
          rep_cnt_d = REP_W'(REP_PERIOD - 1);
          fire_add  = !busy;
        end else begin
          rep_cnt_d = rep_cnt_q - REP_W'(1);
        end
      end
    end

    if (fire_add || fire_clr) begin
      busy_d     = BUSY_W'(2 * PULSE_W - 1);
      clr_kind_d = fire_clr;
    end
    add_d = (busy_d >= BUSY_W'(PULSE_W)) && !clr_kind_d;
    clr_d = (busy_d >= BUSY_W'(PULSE_W)) && clr_kind_d;

    // Blink restarts high on EDIT entry and on each select change.
    if (state_d == ST_EDIT) begin
      if (enter_edit || sel_chg || (blink_cnt_q == '0)) begin
        blink_d     = (enter_edit || sel_chg) ? 1'b1 : ~blink_q;
        blink_cnt_d = BLINK_W'(BLINK_HALF - 1);
      end else begin
        blink_cnt_d = blink_cnt_q - BLINK_W'(1);
      end
    end else begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= ST_RUN;
      adjust_q    <= 1'b1;
      select_q    <= SEL_MS_L;
      add_q       <= 1'b0;
      clr_q       <= 1'b0;
      clr_kind_q  <= 1'b0;
      busy_q      <= '0;
      mode_pend_q <= 1'b0;
      rep_on_q    <= 1'b0;
      rep_cnt_q   <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      adjust_q    <= adjust_d;
      select_q    <= select_d;
      add_q       <= add_d;
      clr_q       <= clr_d;
      clr_kind_q  <= clr_kind_d;
      busy_q      <= busy_d;
      mode_pend_q <= mode_pend_d;
      rep_on_q    <= rep_on_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign adjust = adjust_q;
  assign select = select_q;
  assign add    = add_q;
  assign clr    = clr_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed bench for time_adjust_ctrl with short debounce/repeat/blink timing.
module tb_time_adjust_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 40;
  localparam int unsigned RP  = 10;
  localparam int unsigned PW  = 2;
  localparam int unsigned BH  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys_n;  // 0 mode, 1 next, 2 add, 3 clr
  logic       adjust, add, clr, blink;
  logic [3:0] select;

  time_adjust_ctrl #(
    .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP), .PULSE_W(PW), .BLINK_HALF(BH)
  ) dut (
    .CLOCK_50(clk), .rst(rst),
    .key_mode_n(keys_n[0]), .key_next_n(keys_n[1]),
    .key_add_n(keys_n[2]), .key_clr_n(keys_n[3]),
    .adjust(adjust), .select(select), .add(add), .clr(clr), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int add_cyc = 0;
  int clr_cyc = 0;

  always @(negedge clk) begin
    if (add) add_cyc++;
    if (clr) clr_cyc++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int k, input int hold);
    keys_n[k] = 1'b0;
    idle(hold);
    keys_n[k] = 1'b1;
    idle(12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    int lat, a0, c0, prev, run, clr_rise, clr_hi, add_hi, adj_rise;
    int rises[$];
    int widths[$];
    int rep_exp[7];
    rep_exp = '{7, 47, 57, 67, 77, 87, 97};

    rst    = 1'b1;
    keys_n = 4'hF;
    idle(3);
    rst = 1'b0;

    // Idle after reset: {adjust,select,add,clr,blink} = 1_0000_000
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_outputs", int'({adjust, select, add, clr, blink}), 8'h80);
    end

    // Short press and bouncing mode key are rejected
    keys_n[0] = 1'b0;
    idle(3);
    keys_n[0] = 1'b1;
    idle(10);
    check_eq("short_press_adjust", int'(adjust), 1);
    for (int j = 0; j < 6; j++) begin
      keys_n[0] = ~keys_n[0];
      idle(2);
    end
    idle(10);
    check_eq("bounce_adjust", int'(adjust), 1);

    // Solid mode press: EDIT after DB+3 cycles, blink starts high for BH cycles
    lat = 0;
    keys_n[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!adjust && lat == 0) lat = i;
      if (i == 7)  check_eq("blink_entry", int'(blink), 1);
      if (i == 14) check_eq("blink_last_high", int'(blink), 1);
      if (i == 15) check_eq("blink_first_low", int'(blink), 0);
      if (i == 10) keys_n[0] = 1'b1;
    end
    check_eq("mode_latency", lat, 7);
    check_eq("edit_adjust", int'(adjust), 0);

    // Sixteen next presses walk select 1..15,0
    for (int k = 0; k < 16; k++) begin
      tap(1, 6);
      check_eq("next_select", int'(select), (k + 1) % 16);
    end
    check_eq("next_no_add", add_cyc, 0);
    check_eq("next_no_clr", clr_cyc, 0);

    // Hold add for 100 cycles: pulses at 7, +40, then every 10
    c0   = clr_cyc;
    prev = 0;
    run  = 0;
    keys_n[2] = 1'b0;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      if (add && prev == 0) rises.push_back(i);
      if (add) run++;
      else if (prev != 0) begin
        widths.push_back(run);
        run = 0;
      end
      prev = int'(add);
      if (i == 100) keys_n[2] = 1'b1;
    end
    check_eq("rep_pulse_count", rises.size(), 7);
    for (int j = 0; j < 7; j++) begin
      if (j < rises.size()) check_eq("rep_pulse_at", rises[j], rep_exp[j]);
    end
    foreach (widths[j]) check_eq("rep_pulse_width", widths[j], 2);
    check_eq("rep_no_clr", clr_cyc - c0, 0);
    idle(10);

    // add+clr together: clr wins; mode during the pulse applies after clr falls
    clr_rise = 0;
    clr_hi   = 0;
    add_hi   = 0;
    adj_rise = 0;
    keys_n[2] = 1'b0;
    keys_n[3] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (clr && clr_rise == 0) clr_rise = i;
      if (clr) clr_hi++;
      if (add) add_hi++;
      if (adjust && adj_rise == 0) adj_rise = i;
      if (i == 1) keys_n[0] = 1'b0;
      if (i == 6) begin
        keys_n[2] = 1'b1;
        keys_n[3] = 1'b1;
      end
      if (i == 7) keys_n[0] = 1'b1;
    end
    check_eq("prio_clr_rise", clr_rise, 7);
    check_eq("prio_clr_width", clr_hi, 2);
    check_eq("prio_no_add", add_hi, 0);
    check_eq("pending_mode_rise", adj_rise, 10);
    idle(12);

    // RUN ignores add/clr/next
    a0 = add_cyc;
    c0 = clr_cyc;
    tap(2, 6);
    tap(3, 6);
    tap(1, 6);
    check_eq("run_no_add", add_cyc - a0, 0);
    check_eq("run_no_clr", clr_cyc - c0, 0);
    check_eq("run_select", int'(select), 0);
    check_eq("run_adjust", int'(adjust), 1);

    // Reset during an EDIT add pulse
    tap(0, 6);
    check_eq("reenter_edit", int'(adjust), 0);
    tap(1, 6);
    check_eq("edit_select_1", int'(select), 1);
    keys_n[2] = 1'b0;
    idle(7);
    check_eq("add_before_rst", int'(add), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_pulse", int'({adjust, select, add, clr, blink}), 8'h80);
    rst = 1'b0;
    keys_n[2] = 1'b1;
    idle(20);
    check_eq("after_rst_idle", int'({adjust, select, add, clr, blink}), 8'h80);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
